// File: rtl/alu_share_if.sv
// Request/response bundle between two ALU requesters and the sharing arbiter.
// Port i occupies bit i of the 1-bit-per-port fields and slice i of the packed data fields.
interface alu_share_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [2*CTRL_W-1:0] req_ctrl;
    logic [1:0]          resp_valid;
    logic [1:0]          resp_ready;
    logic [DATA_W-1:0]   resp_result;

    modport master (
        output req_valid, req_a, req_b, req_ctrl, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the EX stage (port 0) and the debug unit (port 1).
// One operation in flight: IDLE accepts, EXEC captures the ALU result, RESP waits for the owner.
module alu_share_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CTRL_W    = 4,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_if.slave        bus,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [CTRL_W-1:0] alu_control_o,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic              owner_q;
    logic              rr_q;       // port favoured on a tie in round-robin mode
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic [DATA_W-1:0] result_q;
    logic [1:0]        resp_valid_q;
    logic [1:0]        grant_c;

    // Winner selection; only meaningful while IDLE.
    always_comb begin
        grant_c = 2'b00;
        if (state_q == IDLE) begin
            if (bus.req_valid == 2'b11) begin
                if ((PRIO_MODE == 1) || !rr_q) begin
                    grant_c = 2'b01;
                end else begin
                    grant_c = 2'b10;
                end
            end else begin
                grant_c = bus.req_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            rr_q         <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            result_q     <= '0;
            resp_valid_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_c != 2'b00) begin
                        owner_q <= grant_c[1];
                        state_q <= EXEC;
                        if (grant_c[1]) begin
                            alu_a_q    <= bus.req_a[DATA_W +: DATA_W];
                            alu_b_q    <= bus.req_b[DATA_W +: DATA_W];
                            alu_ctrl_q <= bus.req_ctrl[CTRL_W +: CTRL_W];
                        end else begin
                            alu_a_q    <= bus.req_a[0 +: DATA_W];
                            alu_b_q    <= bus.req_b[0 +: DATA_W];
                            alu_ctrl_q <= bus.req_ctrl[0 +: CTRL_W];
                        end
                    end
                end
                EXEC: begin
                    result_q     <= alu_result_i;
                    resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready[owner_q]) begin
                        resp_valid_q <= 2'b00;
                        rr_q         <= ~owner_q;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 2'b00;
                end
            endcase
        end
    end

    assign bus.req_ready   = grant_c;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = result_q;
    assign alu_a_o         = alu_a_q;
    assign alu_b_o         = alu_b_q;
    assign alu_control_o   = alu_ctrl_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a round-robin and a fixed-priority instance
// receive identical stimulus, each backed by a small behavioural ALU.
module tb_alu_share_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    logic clk;
    logic rst_n;

    alu_share_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus_rr ();
    alu_share_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus_pr ();

    logic [DATA_W-1:0] rr_alu_a, rr_alu_b, rr_alu_res;
    logic [CTRL_W-1:0] rr_alu_ctrl;
    logic              rr_busy;
    logic [DATA_W-1:0] pr_alu_a, pr_alu_b, pr_alu_res;
    logic [CTRL_W-1:0] pr_alu_ctrl;
    logic              pr_busy;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c);
        case (c)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign rr_alu_res = alu_model(rr_alu_a, rr_alu_b, rr_alu_ctrl);
    assign pr_alu_res = alu_model(pr_alu_a, pr_alu_b, pr_alu_ctrl);

    alu_share_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .PRIO_MODE(0)) u_rr (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus_rr),
        .alu_a_o       (rr_alu_a),
        .alu_b_o       (rr_alu_b),
        .alu_control_o (rr_alu_ctrl),
        .alu_result_i  (rr_alu_res),
        .busy_o        (rr_busy)
    );

    alu_share_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .PRIO_MODE(1)) u_pr (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus_pr),
        .alu_a_o       (pr_alu_a),
        .alu_b_o       (pr_alu_b),
        .alu_control_o (pr_alu_ctrl),
        .alu_result_i  (pr_alu_res),
        .busy_o        (pr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] v,
                           input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                           input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1);
        bus_rr.req_valid = v;
        bus_rr.req_a     = {a1, a0};
        bus_rr.req_b     = {b1, b0};
        bus_rr.req_ctrl  = {c1, c0};
        bus_pr.req_valid = v;
        bus_pr.req_a     = {a1, a0};
        bus_pr.req_b     = {b1, b0};
        bus_pr.req_ctrl  = {c1, c0};
    endtask

    task automatic set_rdy(input logic [1:0] r);
        bus_rr.resp_ready = r;
        bus_pr.resp_ready = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_req(2'b00, 0, 0, 0, 0, 0, 0);
        set_rdy(2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int g_rr[$];
        int r_rr[$];
        int g_pr[$];
        int r_pr[$];
        logic p1_served;
        rst_n = 1'b1;
        set_req(2'b00, 0, 0, 0, 0, 0, 0);
        set_rdy(2'b00);

        // Test 1: reset while RESP holds result 7
        do_reset();
        check("rst_busy", 32'(rr_busy), 32'd0);
        check("rst_resp_valid", 32'(bus_rr.resp_valid), 32'd0);
        set_req(2'b01, 32'd3, 32'd4, OP_ADD, 0, 0, 0);
        @(negedge clk);
        set_req(2'b00, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("t1_pre_result", bus_rr.resp_result, 32'd7);
        check("t1_pre_valid", 32'(bus_rr.resp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t1_rst_result", bus_rr.resp_result, 32'd0);
        check("t1_rst_valid", 32'(bus_rr.resp_valid), 32'd0);
        check("t1_rst_alu_a", rr_alu_a, 32'd0);
        check("t1_rst_alu_b", rr_alu_b, 32'd0);
        check("t1_rst_alu_ctrl", 32'(rr_alu_ctrl), 32'd0);
        check("t1_rst_busy", 32'(rr_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_rdy(2'b11);
        repeat (3) @(negedge clk);
        check("t1_no_resp_after", 32'(bus_rr.resp_valid), 32'd0);
        check("t1_idle_after", 32'(rr_busy), 32'd0);

        // Test 2: port 0 ADD 5+3, timing of ready/valid/busy
        do_reset();
        set_rdy(2'b11);
        set_req(2'b01, 32'd5, 32'd3, OP_ADD, 0, 0, 0);
        #1;
        check("t2_c0_req_ready", 32'(bus_rr.req_ready), 32'd1);
        @(negedge clk);
        set_req(2'b00, 0, 0, 0, 0, 0, 0);
        check("t2_c1_resp_valid", 32'(bus_rr.resp_valid), 32'd0);
        check("t2_c1_busy", 32'(rr_busy), 32'd1);
        check("t2_c1_req_ready", 32'(bus_rr.req_ready), 32'd0);
        @(negedge clk);
        check("t2_c2_resp_valid", 32'(bus_rr.resp_valid), 32'd1);
        check("t2_c2_result", bus_rr.resp_result, 32'd8);
        @(negedge clk);
        check("t2_c3_busy", 32'(rr_busy), 32'd0);
        check("t2_c3_resp_valid", 32'(bus_rr.resp_valid), 32'd0);

        // Tests 3/4: both ports continuously valid, RR vs fixed priority
        do_reset();
        set_rdy(2'b11);
        set_req(2'b11, 32'd10, 32'd4, OP_SUB, 32'hFFFF_FFFF, 32'd0, OP_SLT);
        p1_served = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus_rr.req_ready == 2'b01) g_rr.push_back(0);
            else if (bus_rr.req_ready == 2'b10) g_rr.push_back(1);
            if (bus_rr.resp_valid != 2'b00) r_rr.push_back(int'(bus_rr.resp_result));
            if (bus_pr.req_ready == 2'b01) g_pr.push_back(0);
            else if (bus_pr.req_ready == 2'b10) g_pr.push_back(1);
            if (bus_pr.resp_valid == 2'b01) r_pr.push_back(int'(bus_pr.resp_result));
            if (bus_pr.resp_valid[1] || bus_pr.req_ready[1]) p1_served = 1'b1;
            if (g_rr.size() >= 3 && r_rr.size() >= 3 && g_pr.size() >= 3 && r_pr.size() >= 3)
                break;
            @(negedge clk);
        end
        check("t3_grant_count", 32'(g_rr.size() >= 3), 32'd1);
        check("t3_result_count", 32'(r_rr.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_grant%0d", i), (i < g_rr.size()) ? 32'(g_rr[i]) : 32'hDEAD,
                  32'(i % 2));
            check($sformatf("t3_result%0d", i), (i < r_rr.size()) ? 32'(r_rr[i]) : 32'hDEAD,
                  (i % 2 == 1) ? 32'd1 : 32'd6);
            check($sformatf("t4_grant%0d", i), (i < g_pr.size()) ? 32'(g_pr[i]) : 32'hDEAD,
                  32'd0);
            check($sformatf("t4_result%0d", i), (i < r_pr.size()) ? 32'(r_pr[i]) : 32'hDEAD,
                  32'd6);
        end
        check("t4_p1_never_served", 32'(p1_served), 32'd0);

        // Test 5: lone port 1 ADD wraps to 0, response held under backpressure
        do_reset();
        set_rdy(2'b00);
        set_req(2'b10, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, OP_ADD);
        #1;
        check("t5_p1_granted", 32'(bus_rr.req_ready), 32'd2);
        @(negedge clk);
        set_req(2'b01, 32'd20, 32'd2, OP_SUB, 0, 0, 0);
        #1;
        check("t5_exec_no_accept", 32'(bus_rr.req_ready), 32'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("t5_hold_valid%0d", c), 32'(bus_rr.resp_valid), 32'd2);
            check($sformatf("t5_hold_result%0d", c), bus_rr.resp_result, 32'd0);
            check($sformatf("t5_hold_no_accept%0d", c), 32'(bus_rr.req_ready), 32'd0);
            if (c == 2) set_rdy(2'b01);
            @(negedge clk);
            if (c == 2) set_rdy(2'b00);
        end
        set_rdy(2'b10);
        @(negedge clk);
        set_rdy(2'b11);
        #1;
        check("t5_idle_accept_p0", 32'(bus_rr.req_ready), 32'd1);
        check("t5_valid_cleared", 32'(bus_rr.resp_valid), 32'd0);
        @(negedge clk);
        set_req(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t5_p0_result", bus_rr.resp_result, 32'd18);

        // Test 6: operand change after accept is ignored
        do_reset();
        set_rdy(2'b11);
        set_req(2'b01, 32'd100, 32'd1, OP_ADD, 0, 0, 0);
        @(negedge clk);
        set_req(2'b00, 32'd500, 32'd1, OP_ADD, 0, 0, 0);
        check("t6_alu_a_latched", rr_alu_a, 32'd100);
        @(negedge clk);
        check("t6_result", bus_rr.resp_result, 32'd101);
        check("t6_valid", 32'(bus_rr.resp_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
